// File: rtl/nes_dual_pad_poller_if.sv
// Bundle between the pad poller and its user: poll request, pad pins and
// the published button state.
interface nes_dual_pad_poller_if;
  logic       start;
  logic       nes_data_p1;
  logic       nes_data_p2;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons_p1;
  logic [7:0] buttons_p2;
  logic       valid;
  logic       busy;

  modport master (
    output start,
    output nes_data_p1,
    output nes_data_p2,
    input  nes_latch,
    input  nes_clk,
    input  buttons_p1,
    input  buttons_p2,
    input  valid,
    input  busy
  );

  modport slave (
    input  start,
    input  nes_data_p1,
    input  nes_data_p2,
    output nes_latch,
    output nes_clk,
    output buttons_p1,
    output buttons_p2,
    output valid,
    output busy
  );
endinterface

// File: rtl/nes_dual_pad_poller.sv
// Polls two NES pads in parallel over shared latch/clock pins and publishes
// both 8-bit button states (1 = pressed) with a one-cycle valid strobe.
module nes_dual_pad_poller #(
  parameter int LATCH_CYCLES = 302,
  parameter int HALF_CYCLES  = 150
) (
  input  logic                  clk,
  input  logic                  reset,
  nes_dual_pad_poller_if.slave  bus
);

  localparam int MAX_CYCLES = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_HI,
    CLK_LO,
    DONE
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      idx_reg;
  logic [1:0]      sync_p1_reg;
  logic [1:0]      sync_p2_reg;
  logic [7:0]      shift_p1_reg;
  logic [7:0]      shift_p2_reg;
  logic [7:0]      buttons_p1_reg;
  logic [7:0]      buttons_p2_reg;
  logic            latch_reg;
  logic            nes_clk_reg;
  logic            valid_reg;
  logic            busy_reg;
  logic            bit_p1;
  logic            bit_p2;
  logic            latch_last;
  logic            half_last;

  // Pad data is asynchronous; presetting to 1 keeps a floating pad "released".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p1_reg <= 2'b11;
      sync_p2_reg <= 2'b11;
    end else begin
      sync_p1_reg <= {sync_p1_reg[0], bus.nes_data_p1};
      sync_p2_reg <= {sync_p2_reg[0], bus.nes_data_p2};
    end
  end

  assign bit_p1     = ~sync_p1_reg[1];
  assign bit_p2     = ~sync_p2_reg[1];
  assign latch_last = (cnt_reg == CW'(LATCH_CYCLES - 1));
  assign half_last  = (cnt_reg == CW'(HALF_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      idx_reg        <= 3'd0;
      shift_p1_reg   <= 8'h00;
      shift_p2_reg   <= 8'h00;
      buttons_p1_reg <= 8'h00;
      buttons_p2_reg <= 8'h00;
      latch_reg      <= 1'b0;
      nes_clk_reg    <= 1'b0;
      valid_reg      <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_reg <= LATCH;
            cnt_reg   <= '0;
            latch_reg <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        LATCH: begin
          if (latch_last) begin
            shift_p1_reg[0] <= bit_p1;
            shift_p2_reg[0] <= bit_p2;
            idx_reg         <= 3'd1;
            cnt_reg         <= '0;
            latch_reg       <= 1'b0;
            nes_clk_reg     <= 1'b1;
            state_reg       <= CLK_HI;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        CLK_HI: begin
          if (half_last) begin
            cnt_reg     <= '0;
            nes_clk_reg <= 1'b0;
            state_reg   <= CLK_LO;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        CLK_LO: begin
          if (half_last) begin
            shift_p1_reg[idx_reg] <= bit_p1;
            shift_p2_reg[idx_reg] <= bit_p2;
            cnt_reg               <= '0;
            if (idx_reg == 3'd7) begin
              // Bit 7 lands in the same edge, so merge it into the published value.
              buttons_p1_reg <= {bit_p1, shift_p1_reg[6:0]};
              buttons_p2_reg <= {bit_p2, shift_p2_reg[6:0]};
              valid_reg      <= 1'b1;
              state_reg      <= DONE;
            end else begin
              idx_reg     <= idx_reg + 3'd1;
              nes_clk_reg <= 1'b1;
              state_reg   <= CLK_HI;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.nes_latch  = latch_reg;
  assign bus.nes_clk    = nes_clk_reg;
  assign bus.buttons_p1 = buttons_p1_reg;
  assign bus.buttons_p2 = buttons_p2_reg;
  assign bus.valid      = valid_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_nes_dual_pad_poller.sv
// Bench for nes_dual_pad_poller: a small-timing instance for functional and
// corner cases plus a default-parameter instance for real pin timing.
module tb_nes_dual_pad_poller;

  localparam int LS = 4;
  localparam int HS = 2;
  localparam int LD = 302;
  localparam int HD = 150;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nes_dual_pad_poller_if bus_s ();
  nes_dual_pad_poller_if bus_d ();

  nes_dual_pad_poller #(.LATCH_CYCLES(LS), .HALF_CYCLES(HS)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  nes_dual_pad_poller dut_d (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_d)
  );

  // Pads 0/1 hang off the small instance, 2/3 off the default one.
  logic [7:0] btn [4];
  logic [3:0] disc;
  logic [3:0] pad_data;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pad
    wire lat = (gi < 2) ? bus_s.nes_latch : bus_d.nes_latch;
    wire sck = (gi < 2) ? bus_s.nes_clk : bus_d.nes_clk;
    int  pos = 8;
    // Behavioural 4021: latch reloads, each rising clock exposes the next button.
    always @(posedge lat or posedge sck) begin
      if (lat) pos <= 0;
      else if (pos < 8) pos <= pos + 1;
    end
    assign pad_data[gi] = (disc[gi] || pos >= 8) ? 1'b1 : ~btn[gi][pos[2:0]];
  end

  assign bus_s.nes_data_p1 = pad_data[0];
  assign bus_s.nes_data_p2 = pad_data[1];
  assign bus_d.nes_data_p1 = pad_data[2];
  assign bus_d.nes_data_p2 = pad_data[3];

  bit         dsel = 1'b0;
  logic       m_latch, m_clk, m_valid, m_busy;
  logic [7:0] m_bp1, m_bp2;
  assign m_latch = dsel ? bus_d.nes_latch  : bus_s.nes_latch;
  assign m_clk   = dsel ? bus_d.nes_clk    : bus_s.nes_clk;
  assign m_valid = dsel ? bus_d.valid      : bus_s.valid;
  assign m_busy  = dsel ? bus_d.busy       : bus_s.busy;
  assign m_bp1   = dsel ? bus_d.buttons_p1 : bus_s.buttons_p1;
  assign m_bp2   = dsel ? bus_d.buttons_p2 : bus_s.buttons_p2;

  typedef struct {
    logic [7:0] b1;
    logic [7:0] b2;
    bit         disc1;
    bit         disc2;
    logic [7:0] exp1;
    logic [7:0] exp2;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit v);
    if (dsel) bus_d.start = v;
    else      bus_s.start = v;
  endtask

  // Issue one poll at cycle T and follow it to the valid strobe, checking pin
  // timing and the published values against the pad state seen by the model.
  task automatic do_poll(input int lc, input int hc, input logic [7:0] e1,
                         input logic [7:0] e2, input int poke_a, input int poke_b);
    int  lw, rises, fr, bw, limit;
    bit  prev_clk, seen;
    lw = 0; rises = 0; fr = -1; bw = 0; prev_clk = 1'b0; seen = 1'b0;
    limit = lc + 14 * hc + 20;
    set_start(1'b1);
    for (int i = 1; i <= limit && !seen; i++) begin
      tick();
      set_start((i == poke_a || i == poke_b) ? 1'b1 : 1'b0);
      if (i == 1) chk("latch_at_T+1", int'(m_latch), 1);
      if (m_latch) lw++;
      if (m_busy) bw++;
      if (m_clk && !prev_clk) begin
        rises++;
        if (fr < 0) fr = i;
      end
      prev_clk = m_clk;
      if (m_valid) begin
        seen = 1'b1;
        chk("valid_cycle", i, lc + 14 * hc + 1);
        chk("buttons_p1", int'(m_bp1), int'(e1));
        chk("buttons_p2", int'(m_bp2), int'(e2));
      end
    end
    if (!seen) chk("valid_timeout", 0, 1);
    chk("latch_width", lw, lc);
    chk("clk_pulses", rises, 7);
    chk("first_rise", fr, lc + 1);
    chk("busy_cycles", bw, lc + 14 * hc + 1);
    $display("poll dut=%0d p1=%02h p2=%02h expect %02h/%02h", dsel, m_bp1, m_bp2, e1, e2);
  endtask

  vec_t tbl [6];

  initial begin
    logic [7:0] h1, h2;
    for (int k = 0; k < 4; k++) btn[k] = 8'h00;
    disc = 4'b0000;
    bus_s.start = 1'b0;
    bus_d.start = 1'b0;

    tbl[0] = '{8'h83, 8'h00, 1'b0, 1'b0, 8'h83, 8'h00};
    tbl[1] = '{8'h08, 8'h50, 1'b0, 1'b0, 8'h08, 8'h50};
    tbl[2] = '{8'hff, 8'hff, 1'b0, 1'b0, 8'hff, 8'hff};
    tbl[3] = '{8'h5a, 8'ha5, 1'b0, 1'b1, 8'h5a, 8'h00};
    tbl[4] = '{8'hc3, 8'h3c, 1'b1, 1'b0, 8'h00, 8'h3c};
    tbl[5] = '{8'h01, 8'h80, 1'b0, 1'b0, 8'h01, 8'h80};

    // Reset state
    repeat (3) tick();
    chk("rst_latch", int'(bus_s.nes_latch), 0);
    chk("rst_clk", int'(bus_s.nes_clk), 0);
    chk("rst_valid", int'(bus_s.valid), 0);
    chk("rst_busy", int'(bus_s.busy), 0);
    chk("rst_bp1", int'(bus_s.buttons_p1), 0);
    chk("rst_bp2", int'(bus_s.buttons_p2), 0);
    reset = 1'b0;
    tick();

    // Table-driven polls
    for (int v = 0; v < 6; v++) begin
      btn[0] = tbl[v].b1; btn[1] = tbl[v].b2;
      disc[0] = tbl[v].disc1; disc[1] = tbl[v].disc2;
      do_poll(LS, HS, tbl[v].exp1, tbl[v].exp2, -1, -1);
      repeat (2) tick();
    end
    disc = 4'b0000;

    // start during busy is dropped; start right after DONE is honoured
    btn[0] = 8'h83; btn[1] = 8'h00;
    do_poll(LS, HS, 8'h83, 8'h00, 3, 20);
    tick();
    chk("after_done_valid", int'(bus_s.valid), 0);
    chk("after_done_busy", int'(bus_s.busy), 0);
    btn[0] = 8'h08; btn[1] = 8'h50;
    do_poll(LS, HS, 8'h08, 8'h50, -1, -1);

    // Outputs hold while pads change and no poll runs
    btn[0] = 8'hf0; btn[1] = 8'h0f;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_s.valid || bus_s.buttons_p1 !== 8'h08 || bus_s.buttons_p2 !== 8'h50) begin
        chk("hold_bp1", int'(bus_s.buttons_p1), 8'h08);
        chk("hold_bp2", int'(bus_s.buttons_p2), 8'h50);
        chk("hold_valid", int'(bus_s.valid), 0);
      end
    end
    chk("hold_bp1_end", int'(bus_s.buttons_p1), 8'h08);
    chk("hold_bp2_end", int'(bus_s.buttons_p2), 8'h50);

    // Reset in the middle of LATCH
    bus_s.start = 1'b1;
    tick();
    bus_s.start = 1'b0;
    tick();
    chk("pre_reset_latch", int'(bus_s.nes_latch), 1);
    reset = 1'b1;
    #1;
    chk("midrst_latch", int'(bus_s.nes_latch), 0);
    chk("midrst_busy", int'(bus_s.busy), 0);
    chk("midrst_bp1", int'(bus_s.buttons_p1), 0);
    chk("midrst_bp2", int'(bus_s.buttons_p2), 0);
    chk("midrst_valid", int'(bus_s.valid), 0);
    tick();
    reset = 1'b0;
    begin
      int nv, nb;
      nv = 0; nb = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (bus_s.valid) nv++;
        if (bus_s.busy || bus_s.nes_clk || bus_s.nes_latch) nb++;
      end
      chk("postrst_no_valid", nv, 0);
      chk("postrst_idle", nb, 0);
    end
    btn[0] = 8'h83; btn[1] = 8'h00;
    do_poll(LS, HS, 8'h83, 8'h00, -1, -1);
    tick();

    // Randomized polls against the pad-state model
    for (int r = 0; r < 20; r++) begin
      h1 = 8'($urandom_range(0, 255));
      h2 = 8'($urandom_range(0, 255));
      btn[0] = h1; btn[1] = h2;
      disc[0] = ($urandom_range(0, 3) == 0);
      disc[1] = ($urandom_range(0, 3) == 0);
      do_poll(LS, HS, disc[0] ? 8'h00 : h1, disc[1] ? 8'h00 : h2,
              int'($urandom_range(2, 30)), -1);
      repeat (1 + $urandom_range(0, 3)) tick();
    end
    disc = 4'b0000;

    // Default timing instance
    dsel = 1'b1;
    btn[2] = 8'h90; btn[3] = 8'h2b;
    tick();
    do_poll(LD, HD, 8'h90, 8'h2b, 100, -1);
    tick();
    chk("dflt_busy_after", int'(bus_d.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
